// File: rtl/axi_stream_pkt_arb.sv
// Packet-atomic N-channel AXI-stream arbiter: grants one source per packet (round-robin or
// fixed priority), forwards its beats through a registered 2-entry skid buffer, counts packets.
module axi_stream_pkt_arb #(
   parameter int N_CH      = 2,
   parameter int DAT_BYTS  = 8,
   parameter int CTL_BITS  = 8,
   parameter int MOD_BITS  = $clog2(DAT_BYTS),
   parameter int PRIO_MODE = 0,
   parameter int CNT_BITS  = 16
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic [N_CH-1:0]              i_en,
   input  logic [N_CH-1:0]              i_val,
   output logic [N_CH-1:0]              o_rdy,
   input  logic [N_CH-1:0]              i_sop,
   input  logic [N_CH-1:0]              i_eop,
   input  logic [N_CH-1:0]              i_err,
   input  logic [N_CH*DAT_BYTS*8-1:0]   i_dat,
   input  logic [N_CH*MOD_BITS-1:0]     i_mod,
   input  logic [N_CH*CTL_BITS-1:0]     i_ctl,
   output logic                         o_val,
   input  logic                         i_rdy,
   output logic                         o_sop,
   output logic                         o_eop,
   output logic                         o_err,
   output logic [DAT_BYTS*8-1:0]        o_dat,
   output logic [MOD_BITS-1:0]          o_mod,
   output logic [CTL_BITS-1:0]          o_ctl,
   output logic [$clog2(N_CH)-1:0]      o_chan,
   output logic [N_CH*CNT_BITS-1:0]     o_pkt_cnt,
   output logic                         o_proto_err
);

   localparam int CH_BITS = $clog2(N_CH);
   localparam int DW      = DAT_BYTS * 8;
   localparam int BW      = CH_BITS + 3 + CTL_BITS + MOD_BITS + DW;

   typedef enum logic {S_IDLE, S_LOCK} state_t;

   state_t                   state_q, state_d;
   logic [CH_BITS-1:0]       gnt_q, gnt_d;
   logic [CH_BITS-1:0]       ptr_q, ptr_d;
   logic [N_CH*CNT_BITS-1:0] cnt_q, cnt_d;
   logic                     perr_q, perr_d;
   logic [1:0]               fill_q, fill_d;
   logic [BW-1:0]            head_q, head_d;
   logic [BW-1:0]            skid_q, skid_d;

   logic [N_CH-1:0]          cand;
   logic [N_CH-1:0]          perr_vec;
   logic                     arb_hit;
   logic [CH_BITS-1:0]       arb_ch;
   logic                     perr_hit;
   logic [CH_BITS-1:0]       perr_ch;
   logic                     accept;
   logic                     pop;
   logic                     skid_full;
   logic [BW-1:0]            in_beat;

   assign cand      = i_val & i_en & i_sop;
   assign perr_vec  = i_val & i_en & ~i_sop;
   assign skid_full = (fill_q == 2'd2);
   assign pop       = (fill_q != 2'd0) && i_rdy;

   assign in_beat = {gnt_q, i_sop[gnt_q], i_eop[gnt_q], i_err[gnt_q],
                     i_ctl[gnt_q*CTL_BITS +: CTL_BITS],
                     i_mod[gnt_q*MOD_BITS +: MOD_BITS],
                     i_dat[gnt_q*DW +: DW]};

   // Grant search, plus the lowest channel offering a headless beat while idle
   always_comb begin
      int idx;
      idx      = 0;
      arb_hit  = 1'b0;
      arb_ch   = '0;
      perr_hit = 1'b0;
      perr_ch  = '0;
      if (PRIO_MODE == 1) begin
         for (int c = N_CH - 1; c >= 0; c--) begin
            if (cand[CH_BITS'(c)]) begin
               arb_hit = 1'b1;
               arb_ch  = CH_BITS'(c);
            end
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            idx = (int'(ptr_q) + i) % N_CH;
            if (!arb_hit && cand[CH_BITS'(idx)]) begin
               arb_hit = 1'b1;
               arb_ch  = CH_BITS'(idx);
            end
         end
      end
      for (int c = N_CH - 1; c >= 0; c--) begin
         if (perr_vec[CH_BITS'(c)]) begin
            perr_hit = 1'b1;
            perr_ch  = CH_BITS'(c);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      case (state_q)
         S_IDLE: begin
            if (arb_hit) begin
               state_d = S_LOCK;
               gnt_d   = arb_ch;
            end
         end
         default: begin
            if (accept && i_eop[gnt_q]) state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      o_rdy  = '0;
      accept = 1'b0;
      if (state_q == S_LOCK) begin
         accept = i_val[gnt_q] && !skid_full;
         if (i_rst_n) o_rdy[gnt_q] = !skid_full;
      end else if (i_rst_n && perr_hit) begin
         o_rdy[perr_ch] = 1'b1;
      end
   end

   // Output register is the skid head; the second entry only fills while downstream stalls
   always_comb begin
      fill_d = fill_q;
      head_d = head_q;
      skid_d = skid_q;
      case (fill_q)
         2'd0: begin
            if (accept) begin
               head_d = in_beat;
               fill_d = 2'd1;
            end
         end
         2'd1: begin
            if (accept && pop) begin
               head_d = in_beat;
            end else if (accept) begin
               skid_d = in_beat;
               fill_d = 2'd2;
            end else if (pop) begin
               fill_d = 2'd0;
            end
         end
         default: begin
            if (pop) begin
               head_d = skid_q;
               fill_d = 2'd1;
            end
         end
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      ptr_d  = ptr_q;
      perr_d = (state_q == S_IDLE) && perr_hit;
      if (accept && i_eop[gnt_q]) begin
         ptr_d = (gnt_q == CH_BITS'(N_CH - 1)) ? '0 : gnt_q + CH_BITS'(1);
         for (int c = 0; c < N_CH; c++) begin
            if (gnt_q == CH_BITS'(c) && cnt_q[c*CNT_BITS +: CNT_BITS] != {CNT_BITS{1'b1}})
               cnt_d[c*CNT_BITS +: CNT_BITS] = cnt_q[c*CNT_BITS +: CNT_BITS] + CNT_BITS'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         perr_q  <= 1'b0;
         fill_q  <= 2'd0;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         perr_q  <= perr_d;
         fill_q  <= fill_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   assign o_val       = (fill_q != 2'd0);
   assign o_pkt_cnt   = cnt_q;
   assign o_proto_err = perr_q;
   assign {o_chan, o_sop, o_eop, o_err, o_ctl, o_mod, o_dat} = head_q;

endmodule
